// File: rtl/fpu_addsub_arbiter_pkg.sv
// fpu_arb_pkg: shared types and constants for the FPU add/sub arbiter.
//   FP32_W                 : single-precision operand width
//   FPU_OP_ADD/FPU_OP_SUB  : op encoding on the FPU issue port
//   tag_t                  : in-flight tag {vld, id}, id wide enough for 8 requesters
//   ONE/TWO/THREE          : FP32 constants (1.0, 2.0, 3.0)
//   make_tag               : builds a tag from a valid bit and requester index
package fpu_arb_pkg;

  localparam int FP32_W = 32;

  localparam logic FPU_OP_ADD = 1'b1;
  localparam logic FPU_OP_SUB = 1'b0;

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } tag_t;

  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;

  function automatic tag_t make_tag(input logic vld, input logic [2:0] id);
    tag_t t;
    t.vld = vld;
    t.id  = id;
    return t;
  endfunction

endpackage

// File: rtl/fpu_addsub_arbiter_if.sv
// fpu_addsub_arbiter_if: requester and FPU-side signals of the arbiter.
//   i_req_valid/o_req_ready : per-requester handshake (ready is one-hot grant)
//   i_req_op/i_req_a/i_req_b: per-requester op and packed operands
//   o_fpu_*                 : issue port to the shared FPU
//   i_fpu_result            : FPU result, FPU_LAT cycles after issue
//   o_rsp_valid/o_rsp_data  : one-hot response strobe and result
// Modports: slave = arbiter side, master = requesters + FPU side.
interface fpu_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [NUM_REQ-1:0]        i_req_op;
  logic [NUM_REQ*DATA_W-1:0] i_req_a;
  logic [NUM_REQ*DATA_W-1:0] i_req_b;
  logic                      o_fpu_valid;
  logic                      o_fpu_op;
  logic [DATA_W-1:0]         o_fpu_a;
  logic [DATA_W-1:0]         o_fpu_b;
  logic [DATA_W-1:0]         i_fpu_result;
  logic [NUM_REQ-1:0]        o_rsp_valid;
  logic [DATA_W-1:0]         o_rsp_data;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_fpu_result,
    output o_req_ready, o_fpu_valid, o_fpu_op, o_fpu_a, o_fpu_b,
           o_rsp_valid, o_rsp_data
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_fpu_result,
    input  o_req_ready, o_fpu_valid, o_fpu_op, o_fpu_a, o_fpu_b,
           o_rsp_valid, o_rsp_data
  );

endinterface

// File: rtl/fpu_addsub_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   i_req     : request vector
//   i_ptr     : highest-priority index this cycle
//   o_gnt     : one-hot grant (all-zero when nothing requests)
//   o_gnt_idx : binary index of the granted requester (0 when idle)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  int   idx_s;
  logic found_s;

  // Walk from the pointer, wrapping at N; the first active request wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = int'(i_ptr) + k;
      idx_s = (idx_s >= N) ? (idx_s - N) : idx_s;
      if (!found_s && i_req[idx_s]) begin
        o_gnt[idx_s] = 1'b1;
        o_gnt_idx    = IW'(idx_s);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: round-robin sharing of one pipelined FPU add/sub unit.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : requester handshake, FPU issue port, FPU result, responses
//   o_busy_cnt, o_conflict_cnt : saturating perf counters, present only when
//                                FPU_ARB_PERF_EN is defined
// Accept at cycle t -> issue at t+1 -> result sampled at t+1+FPU_LAT ->
// response strobe at t+2+FPU_LAT.
module fpu_addsub_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int FPU_LAT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef FPU_ARB_PERF_EN
  output logic [15:0] o_busy_cnt,
  output logic [15:0] o_conflict_cnt,
`endif
  fpu_addsub_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   ptr_nxt_s;
  logic               accept_s;
  logic               sel_op_s;
  logic [DATA_W-1:0]  sel_a_s;
  logic [DATA_W-1:0]  sel_b_s;

  logic               fpu_valid_r;
  logic               fpu_op_r;
  logic [DATA_W-1:0]  fpu_a_r;
  logic [DATA_W-1:0]  fpu_b_r;

  // issue_tag_r travels with the issue register; the FPU_LAT stages behind it
  // put the last stage in the same cycle as the matching i_fpu_result.
  tag_t               issue_tag_r;
  tag_t               tag_r [FPU_LAT];
  tag_t               last_tag_s;

  logic [NUM_REQ-1:0] rsp_hot_s;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [DATA_W-1:0]  rsp_data_r;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .i_req     (bus.i_req_valid),
    .i_ptr     (ptr_r),
    .o_gnt     (gnt_s),
    .o_gnt_idx (gnt_idx_s)
  );

  // Grant is purely a function of requests and pointer.
  assign bus.o_req_ready = gnt_s;
  assign accept_s        = |(bus.i_req_valid & gnt_s);
  assign last_tag_s      = tag_r[FPU_LAT-1];

  // Winner's operands and next pointer (winner+1, wrapping at NUM_REQ).
  always_comb begin
    sel_op_s = bus.i_req_op[gnt_idx_s];
    sel_a_s  = bus.i_req_a[int'(gnt_idx_s)*DATA_W +: DATA_W];
    sel_b_s  = bus.i_req_b[int'(gnt_idx_s)*DATA_W +: DATA_W];
    if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + IDX_W'(1);
    end
  end

  // Decode the retiring tag into a one-hot response strobe.
  always_comb begin
    rsp_hot_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_hot_s[k] = last_tag_s.vld && (last_tag_s.id == 3'(k));
    end
  end

  // Round-robin pointer: moves past the winner only on an accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Issue register: strobe every accept, operands hold while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fpu_valid_r <= 1'b0;
      fpu_op_r    <= 1'b0;
      fpu_a_r     <= '0;
      fpu_b_r     <= '0;
    end else begin
      fpu_valid_r <= accept_s;
      if (accept_s) begin
        fpu_op_r <= sel_op_s;
        fpu_a_r  <= sel_a_s;
        fpu_b_r  <= sel_b_s;
      end
    end
  end

  // Tag pipeline: clearing on reset drops every in-flight response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_tag_r <= '0;
      for (int i = 0; i < FPU_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      issue_tag_r <= make_tag(accept_s, 3'(gnt_idx_s));
      tag_r[0]    <= issue_tag_r;
      for (int i = 1; i < FPU_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Response register: capture the FPU result for the retiring tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else begin
      rsp_valid_r <= rsp_hot_s;
      if (last_tag_s.vld) begin
        rsp_data_r <= bus.i_fpu_result;
      end
    end
  end

  assign bus.o_fpu_valid = fpu_valid_r;
  assign bus.o_fpu_op    = fpu_op_r;
  assign bus.o_fpu_a     = fpu_a_r;
  assign bus.o_fpu_b     = fpu_b_r;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_data  = rsp_data_r;

`ifdef FPU_ARB_PERF_EN
  logic [15:0] busy_cnt_r;
  logic [15:0] conflict_cnt_r;
  logic        multi_req_s;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi_req_s = |(bus.i_req_valid & (bus.i_req_valid - NUM_REQ'(1)));

  // Saturating counters for issue-busy and contended cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cnt_r     <= 16'h0000;
      conflict_cnt_r <= 16'h0000;
    end else begin
      if (fpu_valid_r && (busy_cnt_r != 16'hFFFF)) begin
        busy_cnt_r <= busy_cnt_r + 16'h0001;
      end
      if (multi_req_s && (conflict_cnt_r != 16'hFFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 16'h0001;
      end
    end
  end

  assign o_busy_cnt     = busy_cnt_r;
  assign o_conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb_fpu_addsub_arbiter: scoreboard bench for fpu_addsub_arbiter.
// A behavioural FPU (integer-valued floats, fixed latency) sits on the issue
// port. Each accept predicted by the bench's own round-robin model pushes the
// expected issue and response; both are popped when their due cycle arrives.
// Define FPU_ARB_PERF_EN to also check the perf counters.
module tb_fpu_addsub_arbiter;
  import fpu_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_addsub_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef FPU_ARB_PERF_EN
  logic [15:0] busy_cnt;
  logic [15:0] conflict_cnt;
`endif

  fpu_addsub_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .FPU_LAT (LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
`ifdef FPU_ARB_PERF_EN
    .o_busy_cnt     (busy_cnt),
    .o_conflict_cnt (conflict_cnt),
`endif
    .bus            (bus)
  );

  // ---------------- FP helpers (exact for small integers) ----------------
  function automatic int fp_to_int(input logic [31:0] f);
    int e;
    int m;
    int mag;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]});
    if (e < 0) mag = 0;
    else if (e <= 23) mag = m >> (23 - e);
    else mag = m << (e - 23);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] int_to_fp(input int v);
    logic        s;
    logic [31:0] mag;
    logic [31:0] sh;
    int          p;
    if (v == 0) return 32'h0000_0000;
    s   = (v < 0);
    mag = s ? 32'(-v) : 32'(v);
    p   = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) p = i;
    sh = mag << (23 - p);
    return {s, 8'(p + 127), sh[22:0]};
  endfunction

  function automatic logic [31:0] fp_addsub(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? int_to_fp(fp_to_int(a) + fp_to_int(b)) : int_to_fp(fp_to_int(a) - fp_to_int(b));
  endfunction

  // ---------------- behavioural FPU: LAT cycles from issue to result ----------------
  logic [31:0] fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fp_addsub(bus.o_fpu_op, bus.o_fpu_a, bus.o_fpu_b);
    for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign bus.i_fpu_result = fpu_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;
  typedef struct {
    int          due;
    logic [N-1:0] hot;
    logic [31:0] data;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int mptr  = 0;
  int busy_m = 0;
  int conf_m = 0;

  logic [N-1:0] op_v;
  logic [31:0]  a_v [N];
  logic [31:0]  b_v [N];
  logic         use_ovr = 1'b0;
  logic [31:0]  ovr     = 32'h0000_0000;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Compare registered outputs against whatever is due this cycle.
  task automatic check_outputs();
    iss_t ie;
    rsp_t re;
    if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
      ie = iss_q.pop_front();
      check_eq("fpu_valid", 64'(bus.o_fpu_valid), 64'd1);
      check_eq("fpu_op",    64'(bus.o_fpu_op),    64'(ie.op));
      check_eq("fpu_a",     64'(bus.o_fpu_a),     64'(ie.a));
      check_eq("fpu_b",     64'(bus.o_fpu_b),     64'(ie.b));
    end else begin
      check_eq("fpu_idle", 64'(bus.o_fpu_valid), 64'd0);
    end
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      re = rsp_q.pop_front();
      check_eq("rsp_valid", 64'(bus.o_rsp_valid), 64'(re.hot));
      check_eq("rsp_data",  64'(bus.o_rsp_data),  64'(re.data));
    end else begin
      check_eq("rsp_idle", 64'(bus.o_rsp_valid), 64'd0);
    end
  endtask

  // One cycle: check outputs, drive requests, check grant, predict results.
  task automatic step(input logic [N-1:0] v);
    logic [N-1:0] hot;
    int           win;
    check_outputs();
    bus.i_req_valid = v;
    bus.i_req_op    = op_v;
    for (int k = 0; k < N; k++) begin
      bus.i_req_a[k*W +: W] = a_v[k];
      bus.i_req_b[k*W +: W] = b_v[k];
    end
    #1;
    hot = '0;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (win < 0 && v[j]) win = j;
    end
    if (win >= 0) hot[win] = 1'b1;
    check_eq("req_ready", 64'(bus.o_req_ready), 64'(hot));
    if (win >= 0) begin
      iss_q.push_back('{due: cyc + 1, op: op_v[win], a: a_v[win], b: b_v[win]});
      rsp_q.push_back('{due: cyc + 2 + LAT, hot: hot,
                        data: use_ovr ? ovr : fp_addsub(op_v[win], a_v[win], b_v[win])});
      mptr = (win + 1) % N;
      busy_m++;
    end
    if ($countones(v) > 1) conf_m++;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (LAT + 3) step('0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_valid = '0;
    iss_q.delete();
    rsp_q.delete();
    mptr   = 0;
    busy_m = 0;
    conf_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_op    = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    op_v = '0;
    for (int k = 0; k < N; k++) begin
      a_v[k] = 32'h0000_0000;
      b_v[k] = 32'h0000_0000;
    end

    // Reset state
    do_reset();
    check_eq("rst_ready",     64'(bus.o_req_ready), 64'd0);
    check_eq("rst_fpu_valid", 64'(bus.o_fpu_valid), 64'd0);
    check_eq("rst_fpu_op",    64'(bus.o_fpu_op),    64'd0);
    check_eq("rst_fpu_a",     64'(bus.o_fpu_a),     64'd0);
    check_eq("rst_fpu_b",     64'(bus.o_fpu_b),     64'd0);
    check_eq("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    check_eq("rst_rsp_data",  64'(bus.o_rsp_data),  64'd0);
    repeat (2) step('0);

    // Single add on requester 0: 1.0 + 2.0 = 3.0
    op_v[0] = FPU_OP_ADD; a_v[0] = ONE; b_v[0] = TWO;
    use_ovr = 1'b1; ovr = THREE;
    step(4'b0001);
    use_ovr = 1'b0;
    drain();

    // Single sub on requester 2: 3.0 - 1.0 = 2.0
    op_v[2] = FPU_OP_SUB; a_v[2] = THREE; b_v[2] = ONE;
    use_ovr = 1'b1; ovr = TWO;
    step(4'b0100);
    use_ovr = 1'b0;
    drain();

    // All four valid for 8 cycles from pointer 0: strict rotation
    do_reset();
    for (int k = 0; k < N; k++) begin
      op_v[k] = k[0];
      a_v[k]  = int_to_fp(10 * (k + 1));
      b_v[k]  = int_to_fp(k + 1);
    end
    repeat (8) step(4'b1111);
    drain();
`ifdef FPU_ARB_PERF_EN
    check_eq("busy_cnt",     64'(busy_cnt),     64'(busy_m));
    check_eq("conflict_cnt", 64'(conflict_cnt), 64'(conf_m));
`endif

    // Sparse contention: move pointer to 2, then only req0/req1 valid
    step(4'b0010);
    step(4'b0011);
    step(4'b0011);
    drain();

    // Reset mid-flight: no responses for the discarded tags, pointer back to 0
    step(4'b1111);
    step(4'b1111);
    do_reset();
    repeat (LAT + 2) step('0);
    step(4'b1111);
    drain();

    // Random traffic
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N; k++) begin
        op_v[k] = 1'($urandom_range(0, 1));
        a_v[k]  = int_to_fp(int'($urandom_range(0, 500)));
        b_v[k]  = int_to_fp(int'($urandom_range(0, 500)));
      end
      step(N'($urandom_range(0, (1 << N) - 1)));
    end
    drain();
    check_eq("sb_rsp_empty", 64'(rsp_q.size()), 64'd0);
    check_eq("sb_iss_empty", 64'(iss_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
